csr_regfile: RTL and testbench

CSR_REGFILE -- requirements
Module: csr_regfile

---
 rtl/csr_regfile_pkg.sv | 37 +++
 rtl/csr_regfile_if.sv | 24 ++
 rtl/csr_regfile_sync2.sv | 21 ++
 rtl/csr_regfile.sv | 124 ++++++++++++
 tb/tb_csr_regfile.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/csr_regfile_pkg.sv
// Shared register map, access types and bus sizing for csr_regfile.
// Slots 4/5 (IRQ_STATUS/IRQ_ENABLE) are mapped only when CSR_REGFILE_IRQ_EN is defined.
package csr_regfile_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 3;
  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam int unsigned CTRL_OFS       = 0;
  localparam int unsigned CFG0_OFS       = 1;
  localparam int unsigned CFG1_OFS       = 2;
  localparam int unsigned STATUS_OFS     = 3;
  localparam int unsigned IRQ_STATUS_OFS = 4;
  localparam int unsigned IRQ_ENABLE_OFS = 5;
  localparam int unsigned SCRATCH_OFS    = 6;

  typedef enum logic [1:0] {
    ACC_RW   = 2'd0,
    ACC_RO   = 2'd1,
    ACC_W1C  = 2'd2,
    ACC_NONE = 2'd3
  } access_t;

  function automatic access_t slot_access(input int unsigned slot);
    access_t acc;
    case (slot)
      CTRL_OFS, CFG0_OFS, CFG1_OFS, SCRATCH_OFS: acc = ACC_RW;
      STATUS_OFS:                                acc = ACC_RO;
`ifdef CSR_REGFILE_IRQ_EN
      IRQ_STATUS_OFS:                            acc = ACC_W1C;
      IRQ_ENABLE_OFS:                            acc = ACC_RW;
`endif
      default:                                   acc = ACC_NONE;
    endcase
    return acc;
  endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// Bus-bridge request/response bundle: single-cycle request pulse, one-cycle response strobe.
interface csr_regfile_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
);
  logic                    bus_req;
  logic                    bus_req_is_wr;
  logic [ADDR_WIDTH-1:0]   bus_addr;
  logic [DATA_WIDTH-1:0]   bus_wr_data;
  logic [DATA_WIDTH/8-1:0] bus_wr_biten;
  logic                    bus_ready;
  logic                    bus_err;
  logic [DATA_WIDTH-1:0]   bus_rd_data;

  modport master (
    output bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
    input  bus_ready, bus_err, bus_rd_data
  );

  modport slave (
    input  bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
    output bus_ready, bus_err, bus_rd_data
  );
endinterface

// File: rtl/csr_regfile_sync2.sv
// csr_sync2: width-parameterised two-flop synchronizer, two clk cycles of latency.
module csr_sync2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/csr_regfile.sv
// CSR block: 8-slot register file behind a request/response bus, response one cycle after request.
// Interrupt slots and irq output are compiled in only with CSR_REGFILE_IRQ_EN.
module csr_regfile
  import csr_regfile_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CFG0_RESET = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  csr_regfile_if.slave          bus,
  input  logic [DATA_WIDTH-1:0] hw_status,
  input  logic [DATA_WIDTH-1:0] hw_event,
  output logic [DATA_WIDTH-1:0] ctrl_o,
  output logic [DATA_WIDTH-1:0] cfg0_o,
  output logic [DATA_WIDTH-1:0] cfg1_o,
  output logic                  irq
);
  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] ctrl_q, cfg0_q, cfg1_q, scratch_q, status_sync;
  logic [DATA_WIDTH-1:0] be_mask, rd_mux;
  logic [DATA_WIDTH-1:0] ready_data_q;
  logic                  ready_q, err_q, req_err, wr_en;
  logic [31:0]           slot;
  access_t               acc;

  for (genvar k = 0; k < NBYTES; k++) begin : g_be
    assign be_mask[8*k +: 8] = {8{bus.bus_wr_biten[k]}};
  end

  assign slot    = 32'(bus.bus_addr);
  assign acc     = slot_access(slot);
  assign req_err = (acc == ACC_NONE) || (bus.bus_req_is_wr && acc == ACC_RO);
  assign wr_en   = bus.bus_req && bus.bus_req_is_wr && !req_err;

  csr_sync2 #(.WIDTH(DATA_WIDTH)) u_status_sync (
    .clk (clk),
    .rst (rst),
    .d   (hw_status),
    .q   (status_sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      cfg0_q    <= CFG0_RESET;
      cfg1_q    <= '0;
      scratch_q <= '0;
    end else if (wr_en) begin
      case (slot)
        CTRL_OFS:    ctrl_q    <= (ctrl_q    & ~be_mask) | (bus.bus_wr_data & be_mask);
        CFG0_OFS:    cfg0_q    <= (cfg0_q    & ~be_mask) | (bus.bus_wr_data & be_mask);
        CFG1_OFS:    cfg1_q    <= (cfg1_q    & ~be_mask) | (bus.bus_wr_data & be_mask);
        SCRATCH_OFS: scratch_q <= (scratch_q & ~be_mask) | (bus.bus_wr_data & be_mask);
        default: ;
      endcase
    end
  end

`ifdef CSR_REGFILE_IRQ_EN
  logic [DATA_WIDTH-1:0] irq_status_q, irq_enable_q, w1c_clr;
  logic                  irq_q;

  assign w1c_clr = (wr_en && slot == IRQ_STATUS_OFS) ? (bus.bus_wr_data & be_mask) : '0;

  // Events are OR-ed in after the clear so a coincident event wins over W1C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_status_q <= '0;
      irq_enable_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      irq_status_q <= (irq_status_q & ~w1c_clr) | hw_event;
      if (wr_en && slot == IRQ_ENABLE_OFS)
        irq_enable_q <= (irq_enable_q & ~be_mask) | (bus.bus_wr_data & be_mask);
      irq_q <= |(irq_status_q & irq_enable_q);
    end
  end

  assign irq = irq_q;
`else
  logic unused_hw_event;
  assign unused_hw_event = ^hw_event;
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (slot)
      CTRL_OFS:       rd_mux = ctrl_q;
      CFG0_OFS:       rd_mux = cfg0_q;
      CFG1_OFS:       rd_mux = cfg1_q;
      STATUS_OFS:     rd_mux = status_sync;
      SCRATCH_OFS:    rd_mux = scratch_q;
`ifdef CSR_REGFILE_IRQ_EN
      IRQ_STATUS_OFS: rd_mux = irq_status_q;
      IRQ_ENABLE_OFS: rd_mux = irq_enable_q;
`endif
      default:        rd_mux = '0;
    endcase
  end

  // Response strobe follows every request by exactly one cycle; reset drops it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      ready_data_q <= '0;
    end else begin
      ready_q      <= bus.bus_req;
      err_q        <= bus.bus_req && req_err;
      ready_data_q <= (bus.bus_req && !bus.bus_req_is_wr && !req_err) ? rd_mux : '0;
    end
  end

  assign bus.bus_ready   = ready_q;
  assign bus.bus_err     = err_q;
  assign bus.bus_rd_data = ready_data_q;
  assign ctrl_o          = ctrl_q;
  assign cfg0_o          = cfg0_q;
  assign cfg1_o          = cfg1_q;
endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile; adapts to CSR_REGFILE_IRQ_EN being defined or not.
module tb_csr_regfile;
  localparam logic [31:0] CFG0_RST = 32'hA5A5_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] hw_status = '0;
  logic [31:0] hw_event = '0;
  logic [31:0] ctrl_o, cfg0_o, cfg1_o;
  logic        irq;
  int          checks = 0;
  int          errors = 0;

  csr_regfile_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) bus_if ();

  csr_regfile #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .CFG0_RESET(CFG0_RST)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if.slave),
    .hw_status (hw_status),
    .hw_event  (hw_event),
    .ctrl_o    (ctrl_o),
    .cfg0_o    (cfg0_o),
    .cfg1_o    (cfg1_o),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic req, input logic wr, input logic [2:0] addr,
                       input logic [31:0] data, input logic [3:0] be);
    bus_if.bus_req       = req;
    bus_if.bus_req_is_wr = wr;
    bus_if.bus_addr      = addr;
    bus_if.bus_wr_data   = data;
    bus_if.bus_wr_biten  = be;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_rsp(input string tag, input logic exp_err, input logic [31:0] exp_rd);
    check({tag, "_ready"}, {31'd0, bus_if.bus_ready}, 32'd1);
    check({tag, "_err"}, {31'd0, bus_if.bus_err}, {31'd0, exp_err});
    check({tag, "_rd"}, bus_if.bus_rd_data, exp_rd);
  endtask

  task automatic access(input logic wr, input logic [2:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input logic exp_err, input logic [31:0] exp_rd,
                        input string tag);
    drive(1'b1, wr, addr, data, be);
    tick();
    drive(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    check_rsp(tag, exp_err, exp_rd);
  endtask

  initial begin
    drive(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    repeat (3) tick();
    check("rst_ready", {31'd0, bus_if.bus_ready}, 32'd0);
    check("rst_err", {31'd0, bus_if.bus_err}, 32'd0);
    check("rst_rd", bus_if.bus_rd_data, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_cfg0", cfg0_o, CFG0_RST);
    check("rst_ctrl", ctrl_o, 32'd0);
    check("rst_cfg1", cfg1_o, 32'd0);
    rst = 1'b0;
    tick();

    // Full write then readback, with an idle cycle in between.
    access(1'b1, 3'd0, 32'hDEADBEEF, 4'hF, 1'b0, 32'd0, "wr_ctrl");
    check("ctrl_visible", ctrl_o, 32'hDEADBEEF);
    tick();
    check("ready_one_cycle", {31'd0, bus_if.bus_ready}, 32'd0);
    access(1'b0, 3'd0, 32'd0, 4'h0, 1'b0, 32'hDEADBEEF, "rd_ctrl");
    tick();

    // Byte-enable merge.
    access(1'b1, 3'd0, 32'hFFFFFFFF, 4'hF, 1'b0, 32'd0, "wr_ctrl_ones");
    access(1'b1, 3'd0, 32'h00000000, 4'h2, 1'b0, 32'd0, "wr_ctrl_byte1");
    access(1'b0, 3'd0, 32'd0, 4'h0, 1'b0, 32'hFFFF00FF, "rd_ctrl_merge");
    access(1'b1, 3'd0, 32'h12345678, 4'h0, 1'b0, 32'd0, "wr_ctrl_noop");
    check("ctrl_noop_kept", ctrl_o, 32'hFFFF00FF);
    access(1'b1, 3'd2, 32'hCAFE0000, 4'hC, 1'b0, 32'd0, "wr_cfg1_hi");
    check("cfg1_hi", cfg1_o, 32'hCAFE0000);

    // STATUS synchronizer latency: two reads see the old value, the third the new one.
    hw_status = 32'h00C0FFEE;
    drive(1'b1, 1'b0, 3'd3, 32'd0, 4'h0);
    tick();
    check_rsp("status_lat1", 1'b0, 32'd0);
    tick();
    check_rsp("status_lat2", 1'b0, 32'd0);
    tick();
    drive(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    check_rsp("status_lat3", 1'b0, 32'h00C0FFEE);

    // Error slots.
    access(1'b0, 3'd7, 32'd0, 4'h0, 1'b1, 32'd0, "rd_slot7");
    access(1'b1, 3'd7, 32'hFFFFFFFF, 4'hF, 1'b1, 32'd0, "wr_slot7");
    access(1'b1, 3'd3, 32'h00001234, 4'hF, 1'b1, 32'd0, "wr_status");
    access(1'b0, 3'd3, 32'd0, 4'h0, 1'b0, 32'h00C0FFEE, "rd_status_kept");
    check("ctrl_after_err", ctrl_o, 32'hFFFF00FF);

    // Back-to-back write then read of SCRATCH.
    drive(1'b1, 1'b1, 3'd6, 32'h00000055, 4'hF);
    tick();
    drive(1'b1, 1'b0, 3'd6, 32'd0, 4'h0);
    check_rsp("b2b_wr", 1'b0, 32'd0);
    tick();
    drive(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    check_rsp("b2b_rd", 1'b0, 32'h00000055);
    tick();
    check("b2b_idle", {31'd0, bus_if.bus_ready}, 32'd0);

`ifdef CSR_REGFILE_IRQ_EN
    access(1'b1, 3'd5, 32'h00000008, 4'hF, 1'b0, 32'd0, "wr_irq_en");
    hw_event = 32'h8;
    tick();
    hw_event = 32'h0;
    check("irq_lag", {31'd0, irq}, 32'd0);
    tick();
    check("irq_set", {31'd0, irq}, 32'd1);
    // W1C racing a new event on the same bit: the event wins.
    drive(1'b1, 1'b1, 3'd4, 32'h00000008, 4'h1);
    hw_event = 32'h8;
    tick();
    hw_event = 32'h0;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    check_rsp("w1c_race", 1'b0, 32'd0);
    access(1'b0, 3'd4, 32'd0, 4'h0, 1'b0, 32'h00000008, "rd_irq_stat");
    access(1'b1, 3'd4, 32'h00000008, 4'h0, 1'b0, 32'd0, "w1c_no_be");
    access(1'b0, 3'd4, 32'd0, 4'h0, 1'b0, 32'h00000008, "rd_irq_stat_kept");
    access(1'b1, 3'd4, 32'h00000008, 4'h1, 1'b0, 32'd0, "w1c_clear");
    check("irq_still_high", {31'd0, irq}, 32'd1);
    tick();
    check("irq_cleared", {31'd0, irq}, 32'd0);
    hw_event = 32'h8;
    tick();
    hw_event = 32'h0;
    tick();
    check("irq_pre_rst", {31'd0, irq}, 32'd1);
`else
    access(1'b0, 3'd4, 32'd0, 4'h0, 1'b1, 32'd0, "rd_slot4");
    access(1'b1, 3'd5, 32'h00000008, 4'hF, 1'b1, 32'd0, "wr_slot5");
    hw_event = 32'h8;
    tick();
    hw_event = 32'h0;
    tick();
    check("irq_tied", {31'd0, irq}, 32'd0);
`endif

    // Reset hitting the response cycle of a pending read.
    access(1'b1, 3'd1, 32'h00000011, 4'hF, 1'b0, 32'd0, "wr_cfg0");
    check("cfg0_written", cfg0_o, 32'h00000011);
    drive(1'b1, 1'b0, 3'd0, 32'd0, 4'h0);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    #1;
    check("rst_mid_ready", {31'd0, bus_if.bus_ready}, 32'd0);
    check("rst_mid_rd", bus_if.bus_rd_data, 32'd0);
    check("rst_mid_cfg0", cfg0_o, CFG0_RST);
    check("rst_mid_ctrl", ctrl_o, 32'd0);
    check("rst_mid_irq", {31'd0, irq}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ready", {31'd0, bus_if.bus_ready}, 32'd0);
    access(1'b0, 3'd6, 32'd0, 4'h0, 1'b0, 32'd0, "rd_scratch_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
